// File: rtl/e_muldiv_unit_pkg.sv
// Shared definitions for the RV32M execute-stage multiply/divide unit:
// func3 encodings, FSM state type and default datapath width.
package e_muldiv_unit_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/muldiv_sign_ctl.sv
// Sign handling around the unsigned iterative core: operand magnitudes,
// divide-by-zero / overflow shortcuts, and sign correction of the final result.
module muldiv_sign_ctl
    import e_muldiv_unit_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            a_neg,
    output logic            b_neg,
    output logic [XLEN-1:0] a_abs,
    output logic [XLEN-1:0] b_abs,
    output logic            special,
    output logic [XLEN-1:0] special_result,
    input  logic [2:0]      func3_q,
    input  logic            a_neg_q,
    input  logic            b_neg_q,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    output logic [XLEN-1:0] final_result
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic              a_signed;
    logic              b_signed;
    logic              div_zero;
    logic              overflow;
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] prod_fix;

    always_comb begin
        a_signed = (func3 == F3_MULH) || (func3 == F3_MULHSU) ||
                   (func3 == F3_DIV)  || (func3 == F3_REM);
        b_signed = (func3 == F3_MULH) || (func3 == F3_DIV) || (func3 == F3_REM);
        a_neg    = a_signed && rs1_data[XLEN-1];
        b_neg    = b_signed && rs2_data[XLEN-1];
        a_abs    = a_neg ? -rs1_data : rs1_data;
        b_abs    = b_neg ? -rs2_data : rs2_data;

        div_zero = func3[2] && (rs2_data == '0);
        overflow = ((func3 == F3_DIV) || (func3 == F3_REM)) &&
                   (rs1_data == INT_MIN) && (rs2_data == '1);
        special  = div_zero || overflow;

        // func3[1] separates the remainder ops from the quotient ops
        special_result = '0;
        if (div_zero) begin
            special_result = func3[1] ? rs1_data : '1;
        end else if (overflow) begin
            special_result = func3[1] ? '0 : INT_MIN;
        end
    end

    always_comb begin
        product  = {acc_hi, acc_lo};
        prod_fix = (a_neg_q ^ b_neg_q) ? -product : product;
        case (func3_q)
            F3_MUL:                        final_result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  final_result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               final_result = (a_neg_q ^ b_neg_q) ? -acc_lo : acc_lo;
            default:                       final_result = a_neg_q ? -acc_hi : acc_hi;
        endcase
    end

endmodule

// File: rtl/e_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, stalls the pipeline
// while busy and presents a single-cycle done pulse with the result.
module e_muldiv_unit
    import e_muldiv_unit_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_index,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_index_out
);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [2:0]       func3_q;
    logic             a_neg_q;
    logic             b_neg_q;
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;
    logic [XLEN-1:0]  operand;

    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_abs;
    logic [XLEN-1:0]  b_abs;
    logic             special;
    logic [XLEN-1:0]  special_result;
    logic [XLEN-1:0]  final_result;

    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_shift;
    logic             div_ge;
    logic [XLEN-1:0]  div_diff;
    logic [XLEN-1:0]  acc_hi_nxt;
    logic [XLEN-1:0]  acc_lo_nxt;

    muldiv_sign_ctl #(.XLEN(XLEN)) u_sign_ctl (
        .func3          (func3),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .a_neg          (a_neg),
        .b_neg          (b_neg),
        .a_abs          (a_abs),
        .b_abs          (b_abs),
        .special        (special),
        .special_result (special_result),
        .func3_q        (func3_q),
        .a_neg_q        (a_neg_q),
        .b_neg_q        (b_neg_q),
        .acc_hi         (acc_hi_nxt),
        .acc_lo         (acc_lo_nxt),
        .final_result   (final_result)
    );

    assign stall = rst && (((state == IDLE) && start && !flush) || (state == CALC));

    // Multiply shifts the product right through {acc_hi, acc_lo}; divide shifts
    // the dividend left out of acc_lo into the partial remainder in acc_hi.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, operand};
        div_diff  = div_shift[XLEN-1:0] - operand;
        if (func3_q[2]) begin
            acc_hi_nxt = div_ge ? div_diff : div_shift[XLEN-1:0];
            acc_lo_nxt = {acc_lo[XLEN-2:0], div_ge};
        end else begin
            acc_hi_nxt = mul_sum[XLEN:1];
            acc_lo_nxt = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            counter      <= '0;
            func3_q      <= '0;
            a_neg_q      <= 1'b0;
            b_neg_q      <= 1'b0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            operand      <= '0;
            done         <= 1'b0;
            result       <= '0;
            rd_index_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !flush) begin
                        func3_q      <= func3;
                        a_neg_q      <= a_neg;
                        b_neg_q      <= b_neg;
                        rd_index_out <= rd_index;
                        counter      <= '0;
                        acc_hi       <= '0;
                        acc_lo       <= func3[2] ? a_abs : b_abs;
                        operand      <= func3[2] ? b_abs : a_abs;
                        if (special) begin
                            result <= special_result;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        counter <= '0;
                        state   <= IDLE;
                    end else begin
                        acc_hi  <= acc_hi_nxt;
                        acc_lo  <= acc_lo_nxt;
                        counter <= counter + CNT_W'(1);
                        if (counter == CNT_W'(XLEN-1)) begin
                            result <= final_result;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Bench for e_muldiv_unit: directed RV32M cases plus random operations checked
// against a plain-arithmetic reference model, including flush and reset.
module tb_e_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            flush;
    logic [2:0]      func3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_index;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_index_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    e_muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .flush        (flush),
        .func3        (func3),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rd_index     (rd_index),
        .stall        (stall),
        .done         (done),
        .result       (result),
        .rd_index_out (rd_index_out)
    );

    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] expRes;
        int          expLat;
        int          stallCycles;
        int          lat;
        bit          seen;
        expRes = refModel(f, a, b);
        expLat = ((f[2] && b == 0) ||
                  ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : XLEN + 1;
        @(negedge clk);
        func3 = f; rs1_data = a; rs2_data = b; rd_index = rd; start = 1'b1; flush = 1'b0;
        #1;
        stallCycles = stall ? 1 : 0;
        seen = 1'b0;
        lat = 0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen  = 1'b1;
                lat   = i;
                start = 1'b0;
                checkOutput($sformatf("result f3=%0d a=%h b=%h", f, a, b), result, expRes);
                checkOutput($sformatf("rd_out f3=%0d", f), 32'(rd_index_out), 32'(rd));
                checkOutput($sformatf("latency f3=%0d", f), 32'(lat), 32'(expLat));
                checkOutput($sformatf("stall_in_done f3=%0d", f), 32'(stall), 32'd0);
            end else if (stall) begin
                stallCycles++;
            end
        end
        if (!seen) begin
            start = 1'b0;
            total++;
            bad++;
            $error("[TB] FAIL timeout f3=%0d observed=no_done expected=done", f);
        end else begin
            checkOutput($sformatf("stall_cycles f3=%0d", f), 32'(stallCycles), 32'(expLat));
            @(negedge clk);
            checkOutput($sformatf("done_pulse f3=%0d", f), 32'(done), 32'd0);
        end
    endtask

    initial begin
        int doneSeen;
        rst = 1'b0; start = 1'b1; flush = 1'b0; func3 = 3'd0;
        rs1_data = 32'd7; rs2_data = 32'd3; rd_index = 5'd1;
        #12;
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_rd", 32'(rd_index_out), 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;

        $display("[TB] directed multiply/divide cases");
        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6);
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8);
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9);
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10);
        applyStimulus(3'd5, 32'd100, 32'd7, 5'd11);
        applyStimulus(3'd7, 32'd100, 32'd7, 5'd12);
        applyStimulus(3'd5, 32'h1234, 32'd0, 5'd13);
        applyStimulus(3'd7, 32'h1234, 32'd0, 5'd14);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);

        $display("[TB] flush together with start");
        @(negedge clk);
        func3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd_index = 5'd2; start = 1'b1; flush = 1'b1;
        #1;
        checkOutput("flush_start_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checkOutput("flush_start_idle", 32'(stall), 32'd0);

        $display("[TB] flush during CALC");
        @(negedge clk);
        func3 = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3; rd_index = 5'd20; start = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("calc_stall", 32'(stall), 32'd1);
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_calc_stall", 32'(stall), 32'd0);
        checkOutput("flush_calc_done", 32'(done), 32'd0);
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("flush_no_done", 32'(doneSeen), 32'd0);
        applyStimulus(3'd0, 32'd3, 32'd5, 5'd21);

        $display("[TB] reset during CALC");
        @(negedge clk);
        func3 = 3'd0; rs1_data = 32'd11; rs2_data = 32'd13; rd_index = 5'd22; start = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_result", result, 32'd0);
        checkOutput("midreset_stall", 32'(stall), 32'd0);
        checkOutput("midreset_rd", 32'(rd_index_out), 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        applyStimulus(3'd5, 32'd1000, 32'd9, 5'd23);

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), randOperand(), randOperand(), 5'($urandom_range(0, 31)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
